// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the bit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter wide enough to hold 0..w without wrapping
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - one-bit full adder cell
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial add/subtract with valid/ready handshakes
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             carry;
  logic             load, step, finish;
  logic             fa_s, fa_co;

  // The single shared adder cell always looks at the current LSBs and carry
  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state and handshake decode; load/step/finish steer the datapath
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Operand shifters, carry and partial result; subtraction is A + ~B + 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {fa_s, res_sh[WIDTH-1:1]};
      carry  <= fa_co;
      cnt    <= cnt + 1'b1;
    end
  end

  // Result registers load only on the last bit so they hold until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (finish) begin
      sum  <= {fa_s, res_sh[WIDTH-1:1]};
      cout <= fa_co;
      ovf  <= carry ^ fa_co;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic         cout, ovf;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: unsigned result for sum/cout, signed range test for ovf
  function automatic void ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb,
                                 output logic [W-1:0] s, output logic co, output logic ov);
    int ux, uy, sx, sy, r, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!sb) begin
      r  = ux + uy + int'(ci);
      sr = sx + sy + int'(ci);
      co = (r > 255);
    end else begin
      r  = ux - uy;
      sr = sx - sy;
      co = (ux >= uy);
    end
    s  = r[W-1:0];
    ov = (sr > 127) || (sr < -128);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait for out_valid; leaves the DUT in DONE with out_ready=0
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input logic sb, output logic [W-1:0] s, output logic co,
                       output logic ov, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      tick();
      w++;
    end
    checks++;
    if (w >= 40) begin
      errors++;
      $display("FAIL wait_in_ready: in_ready=%0b required 1 within 40 cycles", in_ready);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = x; b = y; cin = ci; sub = sb;
    tick();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    s = sum; co = cout; ov = ovf;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    checks++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%0b out_valid=%0b sum=%h cout=%0b ovf=%0b required 1 0 00 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4] = '{8'h0F, 8'hFF, 8'h7F, 8'h05};
    logic [W-1:0] vb [4] = '{8'h01, 8'h01, 8'h01, 8'h07};
    logic         vs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] es [4] = '{8'h10, 8'h00, 8'h80, 8'hFE};
    logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic         eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], 1'b0, vs[i], s, co, ov, lat);
      checks++;
      if (lat !== W) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, W);
      end
      checks++;
      if ({s, co, ov} !== {es[i], ec[i], eo[i]}) begin
        errors++;
        $display("FAIL directed_result[%0d]: sum=%h cout=%0b ovf=%0b required %h %0b %0b",
                 i, s, co, ov, es[i], ec[i], eo[i]);
      end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, s, es;
    logic ci, sb, co, ov, ec, eo;
    int lat, hold;
    for (int i = 0; i < 24; i++) begin
      x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom); sb = 1'($urandom);
      if (sb) ci = 1'($urandom);
      ref_op(x, y, sb ? 1'b0 : ci, sb, es, ec, eo);
      do_op(x, y, ci, sb, s, co, ov, lat);
      checks++;
      if (lat !== W || {s, co, ov} !== {es, ec, eo}) begin
        errors++;
        $display("FAIL random[%0d] %h %s %h ci=%0b: lat=%0d sum=%h cout=%0b ovf=%0b required lat=%0d %h %0b %0b",
                 i, x, sb ? "-" : "+", y, ci, lat, s, co, ov, W, es, ec, eo);
      end
      hold = $urandom_range(0, 3);
      for (int k = 0; k < hold; k++) tick();
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    do_op(8'h3C, 8'h5A, 1'b1, 1'b0, s, co, ov, lat);
    checks++;
    if ({lat, s, co, ov} !== {W, 8'h97, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bp_result: lat=%0d sum=%h cout=%0b ovf=%0b required %0d 97 0 1", lat, s, co, ov, W);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      tick();
      checks++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {1'b1, 1'b0, 8'h97, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%0b in_ready=%0b sum=%h cout=%0b ovf=%0b required 1 0 97 0 1",
                 i, out_valid, in_ready, sum, cout, ovf);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, sum, cout, ovf} !== {1'b0, 1'b1, 8'h97, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b sum=%h cout=%0b ovf=%0b required 0 1 97 0 1",
               out_valid, in_ready, sum, cout, ovf);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_stay_idle: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] s, es;
    logic co, ov, ec, eo;
    int lat, seen;
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 8'hC3; b = 8'h21; cin = 1'b0; sub = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, sum, cout, ovf} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_async: out_valid=%0b in_ready=%0b sum=%h cout=%0b ovf=%0b required 0 1 00 0 0",
               out_valid, in_ready, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_result: out_valid cycles=%0d required 0", seen);
    end
    // First accept right after reset release
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_op(8'hE0, 8'h30, 1'b0, 1'b1, es, ec, eo);
    do_op(8'hE0, 8'h30, 1'b0, 1'b1, s, co, ov, lat);
    checks++;
    if ({lat, s, co, ov} !== {W, es, ec, eo}) begin
      errors++;
      $display("FAIL abort_next_op: lat=%0d sum=%h cout=%0b ovf=%0b required %0d %h %0b %0b",
               lat, s, co, ov, W, es, ec, eo);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] es;
    logic ec, eo;
    int n, gap;
    ref_op(8'h9A, 8'hB7, 1'b1, 1'b0, es, ec, eo);
    a = 8'h9A; b = 8'hB7; cin = 1'b1; sub = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if ({out_valid, sum, cout, ovf} !== {1'b1, es, ec, eo}) begin
      errors++;
      $display("FAIL b2b_first: out_valid=%0b sum=%h cout=%0b ovf=%0b required 1 %h %0b %0b",
               out_valid, sum, cout, ovf, es, ec, eo);
    end
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!out_valid && gap < 40);
    in_valid = 1'b0;
    checks++;
    if (gap !== W + 2) begin
      errors++;
      $display("FAIL b2b_interval: got %0d cycles required %0d", gap, W + 2);
    end
    checks++;
    if ({sum, cout, ovf} !== {es, ec, eo}) begin
      errors++;
      $display("FAIL b2b_second: sum=%h cout=%0b ovf=%0b required %h %0b %0b", sum, cout, ovf, es, ec, eo);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_drain: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operands a, b, cin, sub are valid this cycle.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in, add mode only.
REQ-009 sub  input  1  mode: 0 = A+B+cin, 1 = A-B.
REQ-010 out_valid  output  1  sum, cout and ovf are valid.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry-out; in sub mode 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-016 in_ready SHALL equal 1 only in IDLE; out_valid SHALL equal 1 only in DONE.
REQ-017 In IDLE, an in_valid&&in_ready edge SHALL capture A, B' (B if sub=0, ~B if sub=1) and the carry (cin if sub=0, 1 if sub=1), clear the bit counter and enter RUN.
REQ-018 In RUN, each cycle SHALL process one bit, LSB first, via one full-adder cell:
- inputs: A[0], B'[0] and the carry register.
- the sum bit shifts into the result MSB; A and B' shift right.
- the carry register takes the cell carry-out.
REQ-019 RUN SHALL last exactly WIDTH cycles; out_valid SHALL rise WIDTH cycles after the accept edge.
REQ-020 On entry to DONE:
- cout SHALL equal the final carry.
- ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-021 In DONE, sum/cout/ovf SHALL hold stable while out_ready=0.
REQ-022 In DONE, out_valid&&out_ready SHALL return the FSM to IDLE on that edge; no same-cycle re-accept.
- Minimum initiation interval: WIDTH+2 cycles.
REQ-023 in_valid and operand changes SHALL be ignored outside IDLE.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL not wrap within an operation.
REQ-025 sum/cout/ovf SHALL hold the last result after leaving DONE, until the next DONE entry.

Reset
REQ-026 rst_n low SHALL asynchronously force:
- state IDLE, counter 0, internal registers 0.
- sum=0, cout=0, ovf=0, out_valid=0, in_ready=1.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation with no result ever presented.
REQ-028 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 Package serial_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the counter-width function.
REQ-030 Sub-module fa_cell SHALL implement the one-bit full adder (a, b, ci -> s, co).
- Single instance inside serial_adder.

Verification (WIDTH=8)
REQ-031 Add: a=0x0F, b=0x01, cin=0, sub=0 -> after 8 cycles, sum=0x10, cout=0, ovf=0.
REQ-032 Add: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
REQ-033 Add: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-034 Sub: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0.
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE; toggle in_valid with new operands -> outputs unchanged, in_ready=0; then out_ready=1 -> IDLE next edge.
REQ-036 Reset: rst_n pulsed low at RUN cycle 4 -> out_valid=0, in_ready=1 immediately; the next operation completes correctly.
